ftdi_reader: RTL and testbench
==============================

FTDI_READER -- requirements
Module: ftdi_reader

Interface
REQ-001 Parameter DEPTH, 16, byte FIFO entries; power of two, 4..64.
REQ-002 Parameter RD_LOW_CYCLES, 3, clocks ftdi_rd is held low per byte; minimum 2.
REQ-003 Parameter RD_HIGH_CYCLES, 4, recovery clocks with ftdi_rd high after each byte; minimum 1.
REQ-004 clock  input  1  system clock, 50 MHz; one clock; reset is synchronous and active-high.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  high permits new FTDI reads.
REQ-007 bus_grant  input  1  high means the FPGA is not driving ADBUS, so a read may start.
REQ-008 rxf  input  1  FTDI RXF#, active-low, asynchronous; low means the FTDI holds a byte.
REQ-009 adbus_in  input  8  FTDI data bus, asynchronous.
REQ-010 data_ready  input  1  downstream accepts the head byte this cycle.
REQ-011 ftdi_rd  output  1  FTDI RD#, active-low, registered.
REQ-012 busy  output  1  high while a read transaction is in RD_LOW or RD_RECOVER.
REQ-013 data_out  output  8  FIFO head byte.
REQ-014 data_valid  output  1  FIFO non-empty.
REQ-015 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 rxf shall pass through a 2-flop synchronizer; all decisions use the synchronized value rxf_s.
REQ-017 The FSM shall have three states: IDLE, RD_LOW and RD_RECOVER.
REQ-018 IDLE->RD_LOW occurs when en && bus_grant && !rxf_s && count < DEPTH; ftdi_rd goes low on the following clock edge.
REQ-019 In RD_LOW, ftdi_rd stays low for exactly RD_LOW_CYCLES clocks.
REQ-020 In the last RD_LOW clock, adbus_in is registered and pushed into the FIFO, and the FSM moves to RD_RECOVER.
REQ-021 In RD_RECOVER, ftdi_rd stays high for RD_HIGH_CYCLES clocks, then the FSM returns to IDLE.
REQ-022 One in-flight read at most; throughput bound one byte per RD_LOW_CYCLES+RD_HIGH_CYCLES+1 clocks.
REQ-023 Deasserting en or bus_grant mid-transaction does not abort it; the byte is still stored, and no new read starts.
REQ-024 The count < DEPTH check at start guarantees the push never sees a full FIFO; no overflow path exists.
REQ-025 The FIFO is first-word-fall-through: data_out is valid in the same cycle data_valid is high.
REQ-026 Pop occurs when data_valid && data_ready; data_ready while empty is ignored.
REQ-027 Simultaneous push and pop leaves count unchanged and preserves order.
REQ-028 Read and write pointers wrap modulo DEPTH; count spans 0..DEPTH.
REQ-029 A byte pushed while the FIFO is empty drives data_valid high the next cycle.

Reset
REQ-030 On reset, the FSM enters IDLE, ftdi_rd=1, busy=0, count=0, data_valid=0, data_out=0 and pointers are cleared, all on the next edge.
REQ-031 Reset mid-RD_LOW drops the in-flight byte and releases ftdi_rd high on the next edge.
REQ-032 The synchronizer flops reset to 1 (RXF# idle).

Structure
REQ-033 The state enum and default timing constants (RD_LOW_CYCLES, RD_HIGH_CYCLES, DEPTH) shall live in shared package laserdrop_pkg.
REQ-034 Storage shall be a separate sub-module byte_fifo (synchronous, FWFT, parameter DEPTH) instantiated once.
REQ-035 No combinational path from any input to ftdi_rd.

Verification
REQ-036 rxf low holding bytes 0x41,0x42,0x43, en=1, grant=1, data_ready=0 -> three RD# pulses, each 3 clocks low and at least 4 high; count=3; data_out=0x41.
REQ-037 rxf held low, data_ready=0, DEPTH=16 -> exactly 16 reads, then ftdi_rd stays high; count=16.
REQ-038 Full FIFO, then data_ready=1 for one cycle -> count=15, and one further read occurs.
REQ-039 en dropped on the 2nd RD_LOW clock -> current byte 0x5A is stored; no further RD# pulse while rxf stays low.
REQ-040 reset asserted on the 2nd RD_LOW clock -> ftdi_rd=1 and count=0 the next cycle; no byte stored.
REQ-041 Streaming with data_ready=1 always -> bytes 0x00..0xFF emerge in order, count never exceeds 1, and a push coincident with a pop keeps count constant.

Source files
------------

// File: rtl/laserdrop_pkg.sv
// Shared definitions for the FTDI receive path.
//   rd_state_t          : read-strobe FSM states
//   DEF_*               : default FIFO depth and RD# timing (in system clocks)
//   max_u               : helper for sizing counters from timing parameters
package laserdrop_pkg;

    localparam int unsigned DEF_DEPTH          = 16;
    localparam int unsigned DEF_RD_LOW_CYCLES  = 3;
    localparam int unsigned DEF_RD_HIGH_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_LOW     = 2'd1,
        ST_RD_RECOVER = 2'd2
    } rd_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ftdi_reader_if.sv
// FTDI async-FIFO read bus plus the downstream byte stream.
//   rxf        : FTDI RXF#, active-low, asynchronous (FTDI -> reader)
//   adbus_in   : FTDI data bus (FTDI -> reader)
//   ftdi_rd    : FTDI RD#, active-low (reader -> FTDI)
//   data_out   : head byte of the reader FIFO (reader -> consumer)
//   data_valid : FIFO non-empty (reader -> consumer)
//   data_ready : consumer takes the head byte this cycle (consumer -> reader)
// master = the reader, slave = the FTDI/consumer side.
interface ftdi_reader_if;

    logic       rxf;
    logic [7:0] adbus_in;
    logic       ftdi_rd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    modport master (
        input  rxf, adbus_in, data_ready,
        output ftdi_rd, data_out, data_valid
    );

    modport slave (
        output rxf, adbus_in, data_ready,
        input  ftdi_rd, data_out, data_valid
    );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
//   clock, reset : system clock, synchronous active-high reset
//   push         : write push_data this cycle (caller guarantees not full)
//   pop_req      : consumer wants the head byte; ignored while empty
//   data_out     : head byte, zero while empty
//   data_valid   : FIFO non-empty
//   count        : occupancy 0..DEPTH
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop_req,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign data_valid = (count != '0);
    assign pop        = pop_req && data_valid;
    assign data_out   = data_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_reader.sv
// Reads bytes from an FTDI async FIFO interface into a local FWFT FIFO.
//   clock, reset : 50 MHz system clock, synchronous active-high reset
//   en           : permits new reads
//   bus_grant    : ADBUS is not driven by the FPGA, a read may start
//   bus          : FTDI RD#/RXF#/ADBUS and the downstream byte stream
//   busy         : a read transaction is in RD_LOW or RD_RECOVER
//   count        : FIFO occupancy
module ftdi_reader
    import laserdrop_pkg::*;
#(
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned RD_LOW_CYCLES  = DEF_RD_LOW_CYCLES,
    parameter int unsigned RD_HIGH_CYCLES = DEF_RD_HIGH_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   bus_grant,
    ftdi_reader_if.master          bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned CW   = $clog2(max_u(RD_LOW_CYCLES, RD_HIGH_CYCLES) + 1);

    rd_state_t     state;
    rd_state_t     state_n;
    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_n;
    logic          rxf_meta;
    logic          rxf_s;
    logic          push;
    logic          start_ok;

    // RXF# idles high, so the synchronizer resets to "no data".
    always_ff @(posedge clock) begin
        if (reset) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
        end else begin
            rxf_meta <= bus.rxf;
            rxf_s    <= rxf_meta;
        end
    end

    // Checking for room at start means the push can never hit a full FIFO.
    assign start_ok = en && bus_grant && !rxf_s && (count < CNTW'(DEPTH));
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cyc         <= '0;
            bus.ftdi_rd <= 1'b1;
        end else begin
            state       <= state_n;
            cyc         <= cyc_n;
            // Registered from the next state so RD# has no input-to-output path.
            bus.ftdi_rd <= (state_n != ST_RD_LOW);
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc + 1'b1;
        push    = 1'b0;
        case (state)
            ST_IDLE: begin
                cyc_n = '0;
                if (start_ok) begin
                    state_n = ST_RD_LOW;
                end
            end
            ST_RD_LOW: begin
                if (cyc == CW'(RD_LOW_CYCLES - 1)) begin
                    push    = 1'b1;
                    state_n = ST_RD_RECOVER;
                    cyc_n   = '0;
                end
            end
            ST_RD_RECOVER: begin
                if (cyc == CW'(RD_HIGH_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                    cyc_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cyc_n   = '0;
            end
        endcase
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (bus.adbus_in),
        .pop_req    (bus.data_ready),
        .data_out   (bus.data_out),
        .data_valid (bus.data_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_ftdi_reader.sv
// Self-checking bench for ftdi_reader: an FTDI device model feeds bytes,
// a transaction-level model predicts RD#, busy and FIFO contents each cycle.
module tb_ftdi_reader;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned L     = 3;
    localparam int unsigned H     = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       bus_grant = 1'b0;
    logic       busy;
    logic [4:0] count;

    ftdi_reader_if bus();

    ftdi_reader #(
        .DEPTH          (DEPTH),
        .RD_LOW_CYCLES  (L),
        .RD_HIGH_CYCLES (H)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .bus_grant (bus_grant),
        .bus       (bus),
        .busy      (busy),
        .count     (count)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    byte unsigned m_q[$];
    logic         m_rd = 1'b1;
    int           m_low_left = 0;
    int           m_rec_left = 0;
    logic         m_sync1 = 1'b1;
    logic         m_sync2 = 1'b1;

    // FTDI device, monitors, consumer log
    byte unsigned dev_q[$];
    byte unsigned popped[$];
    logic         prev_rd = 1'b1;
    int           pulses = 0;
    int           low_len = 0;
    int           high_len = 0;
    bit           seen_pulse = 0;
    int           max_count = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            errors++;
            $display("FAIL %s: got %0d expected >= %0d at %0t", name, act, lim, $time);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected <= %0d at %0t", name, act, lim, $time);
        end
    endtask

    // Predicts the state after the coming clock edge from the current inputs.
    task automatic model_advance();
        int  sz0;
        bit  pop;
        if (reset) begin
            m_q.delete();
            m_rd       = 1'b1;
            m_low_left = 0;
            m_rec_left = 0;
            m_sync1    = 1'b1;
            m_sync2    = 1'b1;
            return;
        end
        sz0 = m_q.size();
        pop = (sz0 > 0) && bus.data_ready;
        if (pop) void'(m_q.pop_front());
        if (m_low_left > 0) begin
            if (m_low_left == 1) begin
                m_q.push_back(bus.adbus_in);
                m_rec_left = H;
                m_rd       = 1'b1;
            end
            m_low_left--;
        end else if (m_rec_left > 0) begin
            m_rec_left--;
        end else if (en && bus_grant && !m_sync2 && sz0 < DEPTH) begin
            m_low_left = L;
            m_rd       = 1'b0;
        end
        m_sync2 = m_sync1;
        m_sync1 = bus.rxf;
    endtask

    task automatic compare();
        check("ftdi_rd", bus.ftdi_rd, m_rd);
        check("busy", busy, int'(m_low_left > 0 || m_rec_left > 0));
        check("count", count, m_q.size());
        check("data_valid", bus.data_valid, int'(m_q.size() > 0));
        check("data_out", bus.data_out, (m_q.size() > 0) ? int'(m_q[0]) : 0);
        if (int'(count) > max_count) max_count = count;
    endtask

    task automatic monitor();
        if (prev_rd == 1'b0 && bus.ftdi_rd == 1'b1 && dev_q.size() > 0)
            void'(dev_q.pop_front());
        if (reset) begin
            low_len    = 0;
            high_len   = 0;
            seen_pulse = 0;
        end else if (bus.ftdi_rd == 1'b0) begin
            if (prev_rd == 1'b1) begin
                pulses++;
                if (seen_pulse) check_ge("rd_high_gap", high_len, H + 1);
                seen_pulse = 1;
                low_len    = 0;
            end
            low_len++;
        end else begin
            if (prev_rd == 1'b0 && seen_pulse) begin
                check("rd_low_width", low_len, L);
                high_len = 0;
            end
            high_len++;
        end
        prev_rd = bus.ftdi_rd;
    endtask

    task automatic drive_dev();
        bus.rxf      = (dev_q.size() == 0);
        bus.adbus_in = (dev_q.size() > 0) ? dev_q[0] : 8'($urandom);
    endtask

    task automatic tick();
        if (bus.data_valid && bus.data_ready) popped.push_back(bus.data_out);
        model_advance();
        @(posedge clock);
        @(negedge clock);
        compare();
        monitor();
        drive_dev();
    endtask

    task automatic do_reset();
        drive_dev();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        popped.delete();
        max_count = 0;
        pulses    = 0;
    endtask

    task automatic wait_rd_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.ftdi_rd == 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_rd_low: no RD# pulse within %0d cycles", budget);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_ready = 1'b0;
        drive_dev();

        // Reset values
        do_reset();
        check("rst_ftdi_rd", bus.ftdi_rd, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_valid", bus.data_valid, 0);
        check("rst_data_out", bus.data_out, 0);

        // Three queued bytes, consumer stalled
        dev_q = '{8'h41, 8'h42, 8'h43};
        en = 1'b1;
        bus_grant = 1'b1;
        do_reset();
        repeat (40) tick();
        check("abc_pulses", pulses, 3);
        check("abc_count", count, 3);
        check("abc_head", bus.data_out, 'h41);

        // Fill to DEPTH, then free one slot
        dev_q.delete();
        for (int i = 0; i < 40; i++) dev_q.push_back(8'(i + 1));
        do_reset();
        repeat (148) tick();
        check("full_pulses", pulses, 16);
        check("full_count", count, 16);
        repeat (20) tick();
        check("full_hold_pulses", pulses, 16);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        check("pop1_count", count, 15);
        repeat (20) tick();
        check("refill_pulses", pulses, 17);
        check("refill_count", count, 16);

        // en dropped during a read
        dev_q = '{8'h5A, 8'h11, 8'h22, 8'h33};
        en = 1'b1;
        do_reset();
        wait_rd_low(50);
        en = 1'b0;
        repeat (40) tick();
        check("en_drop_count", count, 1);
        check("en_drop_head", bus.data_out, 'h5A);
        check("en_drop_pulses", pulses, 1);
        en = 1'b1;

        // Reset during a read
        dev_q = '{8'h77, 8'h88};
        do_reset();
        wait_rd_low(50);
        reset = 1'b1;
        tick();
        check("rst_mid_rd", bus.ftdi_rd, 1);
        check("rst_mid_count", count, 0);
        reset = 1'b0;
        dev_q.delete();
        drive_dev();
        repeat (12) tick();
        check("rst_mid_count_after", count, 0);
        check("rst_mid_valid_after", bus.data_valid, 0);

        // Streaming 0x00..0xFF with an always-ready consumer
        dev_q.delete();
        for (int i = 0; i < 256; i++) dev_q.push_back(8'(i));
        bus.data_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 256 * 8 + 100 && popped.size() < 256; c++) tick();
        check("stream_len", popped.size(), 256);
        for (int i = 0; i < popped.size(); i++) check("stream_byte", popped[i], i);
        check_le("stream_max_count", max_count, 1);

        // Randomized traffic: slow consumer first (fills FIFO), then fast
        dev_q.delete();
        bus.data_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            bus_grant = ($urandom_range(0, 3) != 0);
            if (c < 1500) bus.data_ready = ($urandom_range(0, 15) == 0);
            else          bus.data_ready = ($urandom_range(0, 2) != 0);
            if (dev_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 20);
                for (int k = 0; k < n; k++) dev_q.push_back(8'($urandom));
            end
            drive_dev();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
